// File: rtl/operand_fetch_stage_pkg.sv
// Shared codebase types used by the operand fetch stage.
//   reg_pkg : register file geometry and writeback port record
//   rob_pkg : issued uop record coming out of the ROB / issue queues
//   is_pkg  : exec packet handed to the functional units
package reg_pkg;
  localparam int WORD_SIZE     = 64;
  localparam int NUM_PHYS_REGS = 64;
  localparam int PREG_W        = $clog2(NUM_PHYS_REGS);

  typedef struct packed {
    logic                 valid;
    logic [PREG_W-1:0]    index;
    logic [WORD_SIZE-1:0] data;
  } RegFileWritePort;
endpackage

package rob_pkg;
  localparam int ROB_PTR_W = 5;

  typedef logic [31:0] uop_t;

  typedef struct packed {
    logic                      valid;
    uop_t                      uop;
    logic [ROB_PTR_W-1:0]      ptr;
    logic [reg_pkg::PREG_W-1:0] dest_phys;
    logic [reg_pkg::PREG_W-1:0] r1_phys;
    logic [reg_pkg::PREG_W-1:0] r2_phys;
  } rob_issue;
endpackage

package is_pkg;
  typedef struct packed {
    logic                          valid;
    rob_pkg::uop_t                 uop;
    logic [rob_pkg::ROB_PTR_W-1:0] ptr;
    logic [reg_pkg::PREG_W-1:0]    dest_phys;
    logic [reg_pkg::PREG_W-1:0]    r1_phys;
    logic [reg_pkg::PREG_W-1:0]    r2_phys;
    logic [reg_pkg::WORD_SIZE-1:0] rd_data;
    logic [reg_pkg::WORD_SIZE-1:0] r1_data;
    logic [reg_pkg::WORD_SIZE-1:0] r2_data;
  } exec_packet;
endpackage

// File: rtl/operand_fetch_stage_slot.sv
// operand_fetch_slot: one issue channel of the operand fetch stage.
// Holds a single exec packet register. On accept it captures the uop and
// three operands (rd, r1, r2), each taken from a same-cycle writeback hit
// in preference to the regfile read data. While the packet is stalled it
// keeps snooping writebacks so a held operand never goes stale.
// Ports:
//   clk_in, rst_N_in       clock, async active-low reset
//   flush_in               drop held and incoming packet
//   issue_in / issue_ready_out   issued uop handshake
//   rf_read_en_out / rf_read_index_out / rf_read_data_in  3 regfile slots (rd,r1,r2)
//   wb_in                  writeback bypass ports (lowest index wins)
//   pkt_out / pkt_ready_in registered packet to the FU
module operand_fetch_slot
  import reg_pkg::*, rob_pkg::*, is_pkg::*;
#(
  parameter int NUM_WB    = 4,
  parameter int WORD_SIZE = reg_pkg::WORD_SIZE,
  parameter int PREG_W    = $clog2(reg_pkg::NUM_PHYS_REGS)
) (
  input  logic                              clk_in,
  input  logic                              rst_N_in,
  input  logic                              flush_in,
  input  rob_issue                          issue_in,
  output logic                              issue_ready_out,
  output logic [2:0]                        rf_read_en_out,
  output logic [2:0][PREG_W-1:0]            rf_read_index_out,
  input  logic [2:0][WORD_SIZE-1:0]         rf_read_data_in,
  input  RegFileWritePort [NUM_WB-1:0]      wb_in,
  output exec_packet                        pkt_out,
  input  logic                              pkt_ready_in
);

  exec_packet pkt_q, pkt_d;
  logic       accept;

  // Walk high to low so the lowest-numbered matching port lands last.
  function automatic logic [WORD_SIZE-1:0] byp(
    input logic [PREG_W-1:0]          idx,
    input logic [WORD_SIZE-1:0]       base,
    input RegFileWritePort [NUM_WB-1:0] wb
  );
    logic [WORD_SIZE-1:0] r;
    r = base;
    for (int w = NUM_WB-1; w >= 0; w--)
      if (wb[w].valid && wb[w].index == idx) r = wb[w].data;
    return r;
  endfunction

  assign issue_ready_out = !pkt_q.valid || pkt_ready_in;
  assign accept          = issue_in.valid && issue_ready_out;

  assign rf_read_en_out       = {3{issue_in.valid}};
  assign rf_read_index_out[0] = issue_in.dest_phys;
  assign rf_read_index_out[1] = issue_in.r1_phys;
  assign rf_read_index_out[2] = issue_in.r2_phys;

  always_comb begin
    pkt_d = pkt_q;
    if (pkt_q.valid && !pkt_ready_in) begin
      pkt_d.rd_data = byp(pkt_q.dest_phys, pkt_q.rd_data, wb_in);
      pkt_d.r1_data = byp(pkt_q.r1_phys,   pkt_q.r1_data, wb_in);
      pkt_d.r2_data = byp(pkt_q.r2_phys,   pkt_q.r2_data, wb_in);
    end else if (pkt_q.valid) begin
      pkt_d.valid = 1'b0;
    end
    if (accept) begin
      pkt_d.valid     = 1'b1;
      pkt_d.uop       = issue_in.uop;
      pkt_d.ptr       = issue_in.ptr;
      pkt_d.dest_phys = issue_in.dest_phys;
      pkt_d.r1_phys   = issue_in.r1_phys;
      pkt_d.r2_phys   = issue_in.r2_phys;
      pkt_d.rd_data   = byp(issue_in.dest_phys, rf_read_data_in[0], wb_in);
      pkt_d.r1_data   = byp(issue_in.r1_phys,   rf_read_data_in[1], wb_in);
      pkt_d.r2_data   = byp(issue_in.r2_phys,   rf_read_data_in[2], wb_in);
    end
    // Flush wins over both the held packet and a same-cycle accept.
    if (flush_in) pkt_d = '0;
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) pkt_q <= '0;
    else           pkt_q <= pkt_d;
  end

  assign pkt_out = pkt_q;

endmodule

// File: rtl/operand_fetch_stage.sv
// operand_fetch_stage: per-channel operand fetch between issue and execute.
// Channels (ALU, FPU, LSU, BRU order) are fully independent; each is an
// operand_fetch_slot. Regfile read slots are packed 3 per channel:
// slot 3i = rd, 3i+1 = r1, 3i+2 = r2.
// Ports:
//   clk_in, rst_N_in, flush_in
//   issue_in[NUM_FU] / issue_ready_out[NUM_FU]
//   rf_read_en_out / rf_read_index_out / rf_read_data_in  [3*NUM_FU]
//   wb_in[NUM_WB]          writeback bypass
//   pkt_out[NUM_FU] / pkt_ready_in[NUM_FU]
module operand_fetch_stage
  import reg_pkg::*, rob_pkg::*, is_pkg::*;
#(
  parameter int NUM_FU    = 4,
  parameter int NUM_WB    = 4,
  parameter int WORD_SIZE = reg_pkg::WORD_SIZE,
  parameter int PREG_W    = $clog2(reg_pkg::NUM_PHYS_REGS)
) (
  input  logic                                 clk_in,
  input  logic                                 rst_N_in,
  input  logic                                 flush_in,
  input  rob_issue        [NUM_FU-1:0]         issue_in,
  output logic            [NUM_FU-1:0]         issue_ready_out,
  output logic            [3*NUM_FU-1:0]       rf_read_en_out,
  output logic [3*NUM_FU-1:0][PREG_W-1:0]      rf_read_index_out,
  input  logic [3*NUM_FU-1:0][WORD_SIZE-1:0]   rf_read_data_in,
  input  RegFileWritePort [NUM_WB-1:0]         wb_in,
  output exec_packet      [NUM_FU-1:0]         pkt_out,
  input  logic            [NUM_FU-1:0]         pkt_ready_in
);

  for (genvar i = 0; i < NUM_FU; i++) begin : g_slot
    operand_fetch_slot #(
      .NUM_WB    (NUM_WB),
      .WORD_SIZE (WORD_SIZE),
      .PREG_W    (PREG_W)
    ) u_slot (
      .clk_in            (clk_in),
      .rst_N_in          (rst_N_in),
      .flush_in          (flush_in),
      .issue_in          (issue_in[i]),
      .issue_ready_out   (issue_ready_out[i]),
      .rf_read_en_out    (rf_read_en_out[3*i +: 3]),
      .rf_read_index_out (rf_read_index_out[3*i +: 3]),
      .rf_read_data_in   (rf_read_data_in[3*i +: 3]),
      .wb_in             (wb_in),
      .pkt_out           (pkt_out[i]),
      .pkt_ready_in      (pkt_ready_in[i])
    );
  end

endmodule

// File: doc/operand_fetch_stage.md
OPERAND_FETCH_STAGE -- requirements
Module: operand_fetch_stage

Interface
REQ-001 SHALL have parameter NUM_FU, default 4: number of issue channels (ALU, FPU, LSU, BRU order).
REQ-002 SHALL have parameter NUM_WB, default 4: number of writeback bypass ports.
REQ-003 SHALL have parameter WORD_SIZE, default reg_pkg::WORD_SIZE (64): operand width.
REQ-004 SHALL have parameter PREG_W, default $clog2(reg_pkg::NUM_PHYS_REGS): physical register index width.
REQ-005 SHALL have port clk_in, input, 1: the single clock; all state is on its rising edge.
REQ-006 SHALL have port rst_N_in, input, 1: reset, asynchronous and active-low.
REQ-007 SHALL have port flush_in, input, 1: drop all held and incoming packets.
REQ-008 SHALL have port issue_in, input, NUM_FU x rob_pkg::rob_issue: per-channel issued uop (valid, uop, ptr, dest/r1/r2 phys).
REQ-009 SHALL have port issue_ready_out, output, NUM_FU: per-channel accept.
REQ-010 SHALL have port rf_read_en_out, output, 3*NUM_FU: regfile read enables, channel i uses slots 3i (rd), 3i+1 (r1), 3i+2 (r2).
REQ-011 SHALL have port rf_read_index_out, output, 3*NUM_FU x PREG_W: read indices, same slot order.
REQ-012 SHALL have port rf_read_data_in, input, 3*NUM_FU x WORD_SIZE: combinational same-cycle read data.
REQ-013 SHALL have port wb_in, input, NUM_WB x reg_pkg::RegFileWritePort: FU writeback ports (valid, index, data).
REQ-014 SHALL have port pkt_out, output, NUM_FU x is_pkg::exec_packet: registered exec packets.
REQ-015 SHALL have port pkt_ready_in, input, NUM_FU: per-FU downstream ready.

Function
REQ-016 SHALL give each channel one packet register; latency issue-accept to pkt_out valid is exactly 1 cycle.
REQ-017 SHALL drive issue_ready_out[i] = !pkt_out[i].valid || pkt_ready_in[i], independent of issue_in and flush_in.
REQ-018 SHALL accept issue on a cycle iff issue_in[i].valid && issue_ready_out[i]; full throughput of one packet per channel per cycle.
REQ-019 SHALL assert rf_read_en_out for channel i's three slots only when issue_in[i].valid, with indices copied from issue_in[i].
REQ-020 SHALL select each captured operand from a same-cycle wb_in match (valid && index equal) over rf_read_data_in; on multiple matches lowest wb port index wins.
REQ-021 SHALL, while a packet is held (valid && !pkt_ready_in), snoop wb_in each cycle and overwrite any operand field whose register index matches, same priority as REQ-020.
REQ-022 SHALL clear pkt_out[i].valid when the held packet is consumed and no new issue is accepted.
REQ-023 SHALL keep pkt_out[i] stable (all fields except REQ-021 updates) while valid && !pkt_ready_in[i].
REQ-024 SHALL, on flush_in, clear all pkt_out valid bits on the next edge and discard any issue accepted that cycle.
REQ-025 SHALL treat channels independently; a stall on one SHALL not affect others.

Reset
REQ-026 SHALL, while rst_N_in low, asynchronously force all pkt_out fields to 0 (valid 0); issue_ready_out therefore reads 1.
REQ-027 SHALL, on reset mid-operation, lose all held packets with no partial output.

Structure
REQ-028 SHALL take rob_issue from rob_pkg, RegFileWritePort/WORD_SIZE/NUM_PHYS_REGS from reg_pkg, exec_packet from is_pkg; no new typedefs.
REQ-029 SHALL implement one sub-module operand_fetch_slot (single channel register plus bypass mux), instanced NUM_FU times via generate.

Verification
REQ-030 Issue ALU r1=5 (rf 0x11), r2=6 (rf 0x22), pkt_ready 1 -> next cycle pkt valid, r1 data 0x11, r2 0x22, ready stays 1.
REQ-031 Issue r1=5 with wb port 2 writing reg 5 = 0xAB same cycle, rf returns 0x11 -> captured r1 = 0xAB.
REQ-032 pkt_ready 0 three cycles, wb port 0 writes r2 reg = 0x77 in cycle 2 -> issue_ready 0, held packet r2 becomes 0x77, other fields unchanged.
REQ-033 Held FPU packet plus new issue, flush_in pulsed -> next cycle all valids 0, new issue never appears.
REQ-034 wb ports 1 and 3 both hit reg 9 (0x1, 0x3) on issue -> captured value 0x1.
REQ-035 Reset asserted while LSU packet held -> pkt valid 0 immediately, issue_ready 1, after release no packet emitted.
